// File: rtl/cross_bar_slave_port.sv
// ---------------------------------------------------------------------------
// cross_bar_slave_port
//
// This is the slave-side stage of the cross bar, placed after
// cross_bar_rr_arbiter. It takes the arbiter's one-hot grant and locks onto
// the granted master. It then sends that master's command to one slave and
// returns ack, completion and read data to the same master. Only one
// transaction is in flight at a time, and the grant is ignored while busy.
//
// Optional feature: define CROSS_BAR_TIMEOUT_EN to enable a response
// watchdog. If s_resp does not arrive within TIMEOUT cycles of RESP, the
// watchdog ends the transaction with m_err = 1 and m_rdata = 0.
//
// Ports
//   clk      clock
//   aresetn  asynchronous active-low reset
//   grant    one-hot grant from the arbiter
//   m_req    per-master request, held until that master's m_ack
//   m_cmd    per-master command (1 = write, 0 = read)
//   m_addr   per-master address
//   m_wdata  per-master write data
//   m_ack    one-cycle pulse: command accepted by the slave
//   m_resp   one-cycle pulse: transaction complete
//   m_err    valid with m_resp: 1 = aborted by the watchdog
//   m_rdata  read data, broadcast, valid in the m_resp cycle
//   s_req    slave command valid
//   s_cmd    slave command
//   s_addr   slave address
//   s_wdata  slave write data
//   s_ack    slave accepts the command (handshake = s_req & s_ack)
//   s_resp   slave completion strobe, one cycle
//   s_rdata  slave read data, valid with s_resp
// ---------------------------------------------------------------------------
package cross_bar_pkg;
  localparam int MASTER_N = 4;
endpackage

module cross_bar_slave_port #(
  parameter int MASTER_N = cross_bar_pkg::MASTER_N,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int TIMEOUT  = 255
) (
  input  logic                           clk,
  input  logic                           aresetn,
  input  logic [MASTER_N-1:0]            grant,
  input  logic [MASTER_N-1:0]            m_req,
  input  logic [MASTER_N-1:0]            m_cmd,
  input  logic [MASTER_N-1:0][ADDR_W-1:0] m_addr,
  input  logic [MASTER_N-1:0][DATA_W-1:0] m_wdata,
  output logic [MASTER_N-1:0]            m_ack,
  output logic [MASTER_N-1:0]            m_resp,
  output logic                           m_err,
  output logic [DATA_W-1:0]              m_rdata,
  output logic                           s_req,
  output logic                           s_cmd,
  output logic [ADDR_W-1:0]              s_addr,
  output logic [DATA_W-1:0]              s_wdata,
  input  logic                           s_ack,
  input  logic                           s_resp,
  input  logic [DATA_W-1:0]              s_rdata
);

  typedef enum logic [1:0] {IDLE, CMD, RESP} state_t;

  state_t              state;
  logic [MASTER_N-1:0] sel;         // one-hot owner of the current transaction
  logic                resp_pend;   // s_resp seen together with s_ack in CMD
  logic [DATA_W-1:0]   pend_rdata;  // read data captured with that early s_resp

  logic                grant_valid;
  logic                gnt_cmd;
  logic [ADDR_W-1:0]   gnt_addr;
  logic [DATA_W-1:0]   gnt_wdata;

  // Because the grant is one-hot, an OR-reduction over the masked
  // per-master buses acts as the selection mux.
  // NOTE: combinational logic uses blocking '=' with a default on every path
  // first, so no signal keeps an old value and no latch is inferred.
  always_comb begin
    gnt_cmd   = 1'b0;
    gnt_addr  = '0;
    gnt_wdata = '0;
    for (int i = 0; i < MASTER_N; i++) begin
      if (grant[i]) begin
        gnt_cmd   = gnt_cmd | m_cmd[i];
        gnt_addr  = gnt_addr | m_addr[i];
        gnt_wdata = gnt_wdata | m_wdata[i];
      end
    end
  end

  // A grant is accepted only when it is one-hot and that master is requesting.
  assign grant_valid = $onehot(grant) && ((grant & m_req) != '0);

`ifdef CROSS_BAR_TIMEOUT_EN
  localparam int              CNT_W    = $clog2(TIMEOUT + 1);
  // The last RESP cycle with no s_resp before the watchdog fires.
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
  logic [CNT_W-1:0] tmo_cnt;
`else
  assign m_err = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking '<=' only, so every register
  // samples the values from before the clock edge.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      // NOTE: the datapath registers are also reset. This makes every
      // output 0 out of reset, not just the control bits.
      state      <= IDLE;
      sel        <= '0;
      resp_pend  <= 1'b0;
      pend_rdata <= '0;
      m_ack      <= '0;
      m_resp     <= '0;
      m_rdata    <= '0;
      s_req      <= 1'b0;
      s_cmd      <= 1'b0;
      s_addr     <= '0;
      s_wdata    <= '0;
`ifdef CROSS_BAR_TIMEOUT_EN
      m_err      <= 1'b0;
      tmo_cnt    <= '0;
`endif
    end else begin
      // The ack and response outputs are single-cycle pulses.
      m_ack  <= '0;
      m_resp <= '0;
`ifdef CROSS_BAR_TIMEOUT_EN
      m_err  <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (grant_valid) begin
            sel       <= grant;
            s_cmd     <= gnt_cmd;
            s_addr    <= gnt_addr;
            s_wdata   <= gnt_wdata;
            s_req     <= 1'b1;
            resp_pend <= 1'b0;
            state     <= CMD;
          end
        end

        CMD: begin
          if (s_ack) begin
            s_req      <= 1'b0;
            m_ack      <= sel;
            // An s_resp in the same cycle as s_ack is stored here. It then
            // completes in the first RESP cycle, so m_resp comes right
            // after m_ack.
            resp_pend  <= s_resp;
            pend_rdata <= s_rdata;
`ifdef CROSS_BAR_TIMEOUT_EN
            tmo_cnt    <= '0;
`endif
            state      <= RESP;
          end
        end

        RESP: begin
          if (resp_pend || s_resp) begin
            m_resp    <= sel;
            // Writes leave the broadcast read data unchanged.
            if (!s_cmd) m_rdata <= resp_pend ? pend_rdata : s_rdata;
            resp_pend <= 1'b0;
            state     <= IDLE;
          end
`ifdef CROSS_BAR_TIMEOUT_EN
          else if (tmo_cnt == TMO_LAST) begin
            m_resp  <= sel;
            m_err   <= 1'b1;
            m_rdata <= '0;
            state   <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
`endif
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
